wptr_full: RTL

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/wptr_full_if.sv | 34 +++
 rtl/sync_r2w.sv | 31 +++
 rtl/wptr_full.sv | 87 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer blocks.
// Functions work on a 32-bit word; callers zero-extend narrower pointers and truncate the result.
package fifo_pkg;

  localparam int DEFAULT_ADDR_SIZE = 4;
  localparam int PTR_WORD_W        = 32;

  typedef logic [PTR_WORD_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b = '0;
    for (int i = 0; i < PTR_WORD_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bus of the FIFO write-pointer block: request, read pointer in, RAM/status out.
// The wafull signal exists only when WPTR_FULL_ALMOST_FULL_EN is defined.
interface wptr_full_if #(
  parameter int ADDR_SIZE = fifo_pkg::DEFAULT_ADDR_SIZE
);
  logic                 winc;
  logic [ADDR_SIZE:0]   rptr;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wen;
  logic                 wfull;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 wovf;
`ifdef WPTR_FULL_ALMOST_FULL_EN
  logic                 wafull;
`endif

  modport master (
    output winc, rptr,
    input  waddr, wptr, wen, wfull, wlevel, wovf
`ifdef WPTR_FULL_ALMOST_FULL_EN
    , input wafull
`endif
  );

  modport slave (
    input  winc, rptr,
    output waddr, wptr, wen, wfull, wlevel, wovf
`ifdef WPTR_FULL_ALMOST_FULL_EN
    , output wafull
`endif
  );

endinterface

// File: rtl/sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the write clock domain.
module sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_d, stage1_q;
  logic [WIDTH-1:0] stage2_d, stage2_q;

  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full/level/overflow logic for a Gray-pointer async FIFO.
// Define WPTR_FULL_ALMOST_FULL_EN to add the registered almost-full flag (wafull).
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = DEFAULT_ADDR_SIZE,
  parameter int AFULL_THRESH = 12
) (
  input  logic        wclk,
  input  logic        wrst,
  wptr_full_if.slave  bus
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int MSB   = ADDR_SIZE;

  logic [PTR_W-1:0] wq2_rptr;
  logic [PTR_W-1:0] wq2_bin;
  logic [PTR_W-1:0] full_pattern;
  logic             wen;

  logic [PTR_W-1:0] wbin_d,   wbin_q;
  logic [PTR_W-1:0] wptr_d,   wptr_q;
  logic [PTR_W-1:0] wlevel_d, wlevel_q;
  logic             wfull_d,  wfull_q;
  logic             wovf_d,   wovf_q;
`ifdef WPTR_FULL_ALMOST_FULL_EN
  logic             wafull_d, wafull_q;
`endif

  sync_r2w #(.WIDTH(PTR_W)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.rptr),
    .q   (wq2_rptr)
  );

  // Full when the next write pointer has lapped the read pointer: top two Gray bits inverted.
  always_comb begin
    wen          = bus.winc & ~wfull_q & ~wrst;
    wbin_d       = wbin_q + PTR_W'(wen);
    wptr_d       = PTR_W'(bin2gray(ptr_word_t'(wbin_d)));
    wq2_bin      = PTR_W'(gray2bin(ptr_word_t'(wq2_rptr)));
    full_pattern = {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]};
    wfull_d      = (wptr_d == full_pattern);
    wlevel_d     = wbin_d - wq2_bin;
    wovf_d       = wovf_q | (bus.winc & wfull_q);
`ifdef WPTR_FULL_ALMOST_FULL_EN
    wafull_d     = (wlevel_d >= PTR_W'(AFULL_THRESH));
`endif
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wovf_q   <= 1'b0;
`ifdef WPTR_FULL_ALMOST_FULL_EN
      wafull_q <= 1'b0;
`endif
    end else begin
      thresh_legal: assert (AFULL_THRESH >= 1 && AFULL_THRESH < DEPTH);
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wovf_q   <= wovf_d;
`ifdef WPTR_FULL_ALMOST_FULL_EN
      wafull_q <= wafull_d;
`endif
    end
  end

  assign bus.waddr  = wbin_q[ADDR_SIZE-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wen    = wen;
  assign bus.wfull  = wfull_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wovf   = wovf_q;
`ifdef WPTR_FULL_ALMOST_FULL_EN
  assign bus.wafull = wafull_q;
`endif

endmodule
